// File: rtl/control_secded_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | secded_pkg                                                           |
// | Shared types and constants for the 8-bit SECDED receive/correct path |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package secded_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURA  = 2'd1,
      SINDROME = 2'd2,
      CORRIGE  = 2'd3
   } estado_t;

   typedef enum logic [1:0] {
      SIN_ERROR    = 2'd0,
      ERROR_SIMPLE = 2'd1,
      ERROR_DOBLE  = 2'd2
   } clase_t;

   // Bit positions inside the received word (g0 w3 w2 w1 p2 w0 p1 p0)
   localparam int BIT_P0 = 0;
   localparam int BIT_P1 = 1;
   localparam int BIT_W0 = 2;
   localparam int BIT_P2 = 3;
   localparam int BIT_W1 = 4;
   localparam int BIT_W2 = 5;
   localparam int BIT_W3 = 6;
   localparam int BIT_G0 = 7;

   // pos_error layout {gp, s2, s1, s0}
   localparam int POS_S0 = 0;
   localparam int POS_S2 = 2;
   localparam int POS_GP = 3;

   // Global parity set means an odd number of flips: assume one, correctable.
   // Even parity with a non-zero syndrome can only be two flips.
   function automatic clase_t clasificar(input logic [2:0] s, input logic gp);
      clase_t c;
      if (gp)
         c = ERROR_SIMPLE;
      else if (s != 3'd0)
         c = ERROR_DOBLE;
      else
         c = SIN_ERROR;
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/control_secded_antirrebote.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | antirrebote                                                          |
// | 2-FF synchronizer, debounce counter and rising-edge pulse for a      |
// | mechanical push button                                               |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module antirrebote #(
   parameter int DEB_CICLOS = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic boton_i,
   output logic pulso_o
);

   localparam int            CW      = (DEB_CICLOS > 2) ? $clog2(DEB_CICLOS) : 1;
   localparam logic [CW-1:0] CNT_FIN = CW'(DEB_CICLOS - 1);
   localparam logic [CW-1:0] CNT_UNO = CW'(1);

   logic          sinc_m_q;
   logic          sinc_q;
   logic          nivel_q, nivel_d;
   logic          pulso_q, pulso_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Count consecutive cycles in which the synced input disagrees with the
   // accepted level; any agreement restarts the count.
   always_comb begin
      cnt_d   = '0;
      nivel_d = nivel_q;
      pulso_d = 1'b0;
      if (sinc_q != nivel_q) begin
         if (cnt_q == CNT_FIN) begin
            nivel_d = sinc_q;
            pulso_d = sinc_q;
         end else begin
            cnt_d = cnt_q + CNT_UNO;
         end
      end
   end

   // Synchronizer chain and debounce state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sinc_m_q <= 1'b0;
         sinc_q   <= 1'b0;
         nivel_q  <= 1'b0;
         pulso_q  <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sinc_m_q <= boton_i;
         sinc_q   <= sinc_m_q;
         nivel_q  <= nivel_d;
         pulso_q  <= pulso_d;
         cnt_q    <= cnt_d;
      end
   end

   assign pulso_o = pulso_q;

endmodule
`default_nettype wire

// File: rtl/control_secded.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_secded                                                       |
// | Capture, syndrome, classify and correct an 8-bit SECDED word on a    |
// | debounced button press; keeps saturating error counters              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
// Each state is entered on the edge that performs its work: the word is
// registered on IDLE->CAPTURA, the syndrome on CAPTURA->SINDROME and the
// results on SINDROME->CORRIGE, so listo is high while in CORRIGE, three
// cycles after the button pulse.
module control_secded
   import secded_pkg::*;
#(
   parameter int DEB_CICLOS = 50000,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       conmutador_8,
   input  logic             boton_i,
   input  logic             borrar_cnt,
   output logic [3:0]       w_corregida_b4,
   output logic [3:0]       pos_error,
   output logic             error_simple,
   output logic             error_doble,
   output logic             listo,
   output logic             ocupado,
   output logic [CNT_W-1:0] cnt_simple,
   output logic [CNT_W-1:0] cnt_doble
);

   localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);

   estado_t          estado_q, estado_d;
   logic             pulso;
   logic [7:0]       sw_m_q, sw_q;
   logic [7:0]       palabra_q;
   logic [2:0]       sindrome_q, sindrome;
   logic             gp_q, gp;
   clase_t           clase;
   logic [7:0]       mascara, corregida;
   logic [3:0]       datos_q, pos_q;
   logic             simple_q, doble_q, listo_q;
   logic [CNT_W-1:0] cnt_s_q, cnt_d_q;

   antirrebote #(
      .DEB_CICLOS(DEB_CICLOS)
   ) u_antirrebote (
      .clk     (clk),
      .rst     (rst),
      .boton_i (boton_i),
      .pulso_o (pulso)
   );

   // Two-stage synchronizer for the switch word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_m_q <= '0;
         sw_q   <= '0;
      end else begin
         sw_m_q <= conmutador_8;
         sw_q   <= sw_m_q;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) estado_q <= IDLE;
      else     estado_q <= estado_d;
   end

   // Next-state logic; presses outside IDLE are dropped
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         IDLE:     if (pulso) estado_d = CAPTURA;
         CAPTURA:  estado_d = SINDROME;
         SINDROME: estado_d = CORRIGE;
         CORRIGE:  estado_d = IDLE;
         default:  estado_d = IDLE;
      endcase
   end

   // Syndrome bits, classification and single-bit correction mask
   always_comb begin
      sindrome[0] = palabra_q[BIT_P0] ^ palabra_q[BIT_W0] ^ palabra_q[BIT_W1] ^ palabra_q[BIT_W3];
      sindrome[1] = palabra_q[BIT_P1] ^ palabra_q[BIT_W0] ^ palabra_q[BIT_W2] ^ palabra_q[BIT_W3];
      sindrome[2] = palabra_q[BIT_P2] ^ palabra_q[BIT_W1] ^ palabra_q[BIT_W2] ^ palabra_q[BIT_W3];
      gp          = ^palabra_q;
      clase       = clasificar(sindrome_q, gp_q);
      mascara     = '0;
      if (clase == ERROR_SIMPLE) begin
         if (sindrome_q == 3'd0) mascara[BIT_G0] = 1'b1;
         else                    mascara[sindrome_q - 3'd1] = 1'b1;
      end
      corregida = palabra_q ^ mascara;
   end

   // Capture, syndrome and result registers; listo is a one-cycle strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         palabra_q  <= '0;
         sindrome_q <= '0;
         gp_q       <= 1'b0;
         datos_q    <= '0;
         pos_q      <= '0;
         simple_q   <= 1'b0;
         doble_q    <= 1'b0;
         listo_q    <= 1'b0;
      end else begin
         listo_q <= 1'b0;
         if (estado_q == IDLE && pulso)
            palabra_q <= sw_q;
         if (estado_q == CAPTURA) begin
            sindrome_q <= sindrome;
            gp_q       <= gp;
         end
         if (estado_q == SINDROME) begin
            datos_q                <= {corregida[BIT_W3], corregida[BIT_W2],
                                       corregida[BIT_W1], corregida[BIT_W0]};
            pos_q[POS_GP]          <= gp_q;
            pos_q[POS_S2:POS_S0]   <= sindrome_q;
            simple_q               <= (clase == ERROR_SIMPLE);
            doble_q                <= (clase == ERROR_DOBLE);
            listo_q                <= 1'b1;
         end
      end
   end

   // Saturating error counters; clear wins over a same-cycle increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_s_q <= '0;
         cnt_d_q <= '0;
      end else if (borrar_cnt) begin
         cnt_s_q <= '0;
         cnt_d_q <= '0;
      end else if (estado_q == SINDROME) begin
         if (clase == ERROR_SIMPLE && cnt_s_q != '1) cnt_s_q <= cnt_s_q + CNT_UNO;
         if (clase == ERROR_DOBLE  && cnt_d_q != '1) cnt_d_q <= cnt_d_q + CNT_UNO;
      end
   end

   assign w_corregida_b4 = datos_q;
   assign pos_error      = pos_q;
   assign error_simple   = simple_q;
   assign error_doble    = doble_q;
   assign listo          = listo_q;
   assign ocupado        = (estado_q != IDLE);
   assign cnt_simple     = cnt_s_q;
   assign cnt_doble      = cnt_d_q;

endmodule
`default_nettype wire
